// File: rtl/seq_pkg.sv
// Shared constants for the sequence-detector path: serializer and detector state
// encodings plus the default serializer word width.
package seq_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_e;

  // Moore detector for 1011 (overlapping); D_S1011 is the output state.
  typedef enum logic [2:0] {
    D_S0    = 3'd0,
    D_S1    = 3'd1,
    D_S10   = 3'd2,
    D_S101  = 3'd3,
    D_S1011 = 3'd4
  } det_state_e;

endpackage

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and shifts
// them out one bit per clock, gapless across back-to-back words. All outputs registered.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             din_ready_q, din_ready_d;
  logic             handshake;

  // Word normalised so the first bit to send always sits at WIDTH-1.
  logic [WIDTH-1:0] din_ord;

  generate
    if (MSB_FIRST) begin : g_msb
      assign din_ord = din;
    end else begin : g_lsb
      for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign din_ord[i] = din[WIDTH-1-i];
      end
    end
  endgenerate

  assign handshake = din_valid && din_ready_q;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    x_d     = 1'b0;
    if (handshake) begin
      // x carries the head bit directly; sreg keeps only the bits still to go.
      state_d = S_SHIFT;
      x_d     = din_ord[WIDTH-1];
      sreg_d  = {din_ord[WIDTH-2:0], 1'b0};
      cnt_d   = '0;
    end else if (state_q == S_SHIFT && cnt_q != CntLast) begin
      x_d    = sreg_q[WIDTH-1];
      sreg_d = sreg_q << 1;
      cnt_d  = cnt_q + CntW'(1);
    end else begin
      state_d = S_IDLE;
      sreg_d  = '0;
      cnt_d   = '0;
    end
    x_valid_d     = (state_d == S_SHIFT);
    frame_start_d = handshake;
    din_ready_d   = (state_d == S_IDLE) || (cnt_d == CntLast);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      sreg_q        <= '0;
      cnt_q         <= '0;
      x_q           <= 1'b0;
      x_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
      din_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sreg_q        <= sreg_d;
      cnt_q         <= cnt_d;
      x_q           <= x_d;
      x_valid_q     <= x_valid_d;
      frame_start_q <= frame_start_d;
      din_ready_q   <= din_ready_d;
    end
  end

  assign x           = x_q;
  assign x_valid     = x_valid_q;
  assign busy        = x_valid_q;
  assign frame_start = frame_start_q;
  assign din_ready   = din_ready_q;

endmodule
